// File: rtl/layer_ofm_pack_save.sv
// Purpose : packs IN_W-bit ofm words into PACK-word lines and writes them round-robin over NUM_BANK banks.
// Latency : line write (o_we/o_wdata/o_addr) is registered, one cycle after the last word of the line.
// Backpressure: none; one word accepted every cycle i_vld=1, gaps allowed.
//
// Ports:
//   clk, rstn        rising-edge clock, asynchronous active-low reset
//   i_vld/i_ofm      ofm word stream
//   i_last           final word of a layer (qualified by i_vld); flushes a partial line
//   i_base           start address for every bank, sampled on a layer's first word
//   o_wdata          packed line, word k at [k*IN_W +: IN_W]
//   o_we             one-hot bank write strobe
//   o_addr           registered per-bank address, bank b at [b*ADDR_W +: ADDR_W]
//   o_busy           layer in progress
//   o_done           pulses with the layer's final write
//   o_ovf            (LAYER_SAVE_OVF_EN only) sticky pointer-wrap flag
// Optional feature macro: LAYER_SAVE_OVF_EN
module layer_ofm_pack_save #(
  parameter int IN_W     = 32,
  parameter int PACK     = 4,
  parameter int NUM_BANK = 16,
  parameter int ADDR_W   = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_vld,
  input  logic [IN_W-1:0]              i_ofm,
  input  logic                         i_last,
  input  logic [ADDR_W-1:0]            i_base,
  output logic [IN_W*PACK-1:0]         o_wdata,
  output logic [NUM_BANK-1:0]          o_we,
  output logic [NUM_BANK*ADDR_W-1:0]   o_addr,
  output logic                         o_busy,
  output logic                         o_done
`ifdef LAYER_SAVE_OVF_EN
  ,
  output logic                         o_ovf
`endif
);

  localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BANK_W = $clog2(NUM_BANK);

  typedef enum logic {S_IDLE, S_PACK} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [BANK_W-1:0]       bank_idx;
  logic [ADDR_W-1:0]       ptr [NUM_BANK];
  logic [IN_W*PACK-1:0]    line, next_line;
  logic                    first, line_full, wr, sup;
  logic [ADDR_W-1:0]       ptr_cur;
`ifdef LAYER_SAVE_OVF_EN
  logic [NUM_BANK-1:0]     wrapped;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_vld && !i_last) state_nxt = S_PACK;
      S_PACK:  if (i_vld && i_last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy    = (state == S_PACK);
  assign first     = (state == S_IDLE);
  assign line_full = (cnt == CNT_W'(PACK - 1));
  assign wr        = i_vld && (line_full || i_last);
  // On a layer's first word the pointers are being loaded this very edge,
  // so the write address must come straight from i_base.
  assign ptr_cur   = first ? i_base : ptr[bank_idx];
`ifdef LAYER_SAVE_OVF_EN
  assign sup       = first ? 1'b0 : wrapped[bank_idx];
`else
  assign sup       = 1'b0;
`endif

  // Lane 0 starts a fresh line, which clears all upper lanes so a flushed
  // partial line carries zeros above the last real word.
  always_comb begin
    next_line = (cnt == '0) ? '0 : line;
    for (int k = 0; k < PACK; k++) begin
      if (CNT_W'(k) == cnt) next_line[k*IN_W +: IN_W] = i_ofm;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      bank_idx <= '0;
      line     <= '0;
      o_wdata  <= '0;
      o_we     <= '0;
      o_addr   <= '0;
      o_done   <= 1'b0;
      for (int b = 0; b < NUM_BANK; b++) ptr[b] <= '0;
`ifdef LAYER_SAVE_OVF_EN
      wrapped  <= '0;
      o_ovf    <= 1'b0;
`endif
    end else begin
      o_we   <= '0;
      o_done <= 1'b0;
      if (i_vld) begin
        line <= next_line;
        if (first) begin
          for (int b = 0; b < NUM_BANK; b++) ptr[b] <= i_base;
`ifdef LAYER_SAVE_OVF_EN
          wrapped <= '0;
          o_ovf   <= 1'b0;
`endif
        end
        if (wr) begin
          cnt     <= '0;
          o_done  <= i_last;
          o_wdata <= next_line;
          if (i_last || bank_idx == BANK_W'(NUM_BANK - 1)) bank_idx <= '0;
          else                                             bank_idx <= bank_idx + 1'b1;
          if (!sup) begin
            o_we <= NUM_BANK'(1) << bank_idx;
            for (int b = 0; b < NUM_BANK; b++) begin
              if (BANK_W'(b) == bank_idx) o_addr[b*ADDR_W +: ADDR_W] <= ptr_cur;
            end
            ptr[bank_idx] <= ptr_cur + 1'b1;
`ifdef LAYER_SAVE_OVF_EN
            // Writing the top address means the next write to this bank would wrap.
            if (&ptr_cur) begin
              wrapped[bank_idx] <= 1'b1;
              o_ovf             <= 1'b1;
            end
`endif
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_ofm_pack_save.sv
module tb_layer_ofm_pack_save;
  localparam int IN_W = 32;
  localparam int PACK = 4;
  localparam int NB   = 16;
  localparam int AW   = 10;
  localparam int MAXA = (1 << AW) - 1;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 i_vld = 1'b0;
  logic [IN_W-1:0]      i_ofm = '0;
  logic                 i_last = 1'b0;
  logic [AW-1:0]        i_base = '0;
  logic [IN_W*PACK-1:0] o_wdata;
  logic [NB-1:0]        o_we;
  logic [NB*AW-1:0]     o_addr;
  logic                 o_busy;
  logic                 o_done;
`ifdef LAYER_SAVE_OVF_EN
  logic                 o_ovf;
`endif

  layer_ofm_pack_save #(.IN_W(IN_W), .PACK(PACK), .NUM_BANK(NB), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_ofm(i_ofm), .i_last(i_last), .i_base(i_base),
    .o_wdata(o_wdata), .o_we(o_we), .o_addr(o_addr), .o_busy(o_busy), .o_done(o_done)
`ifdef LAYER_SAVE_OVF_EN
    , .o_ovf(o_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a layer is a list of words; line L = words [L*PACK, L*PACK+PACK)
  // goes to bank L % NB at address base + L / NB.
  bit            m_active;
  int            m_base, m_lines, m_nw;
  bit            m_ovf;
  logic [IN_W-1:0] m_buf [PACK];
  logic [AW-1:0] exp_addr [NB];

  task automatic model_reset();
    m_active = 0; m_base = 0; m_lines = 0; m_nw = 0; m_ovf = 0;
    for (int b = 0; b < NB; b++) exp_addr[b] = '0;
  endtask

  task automatic step(input bit vld, input logic [IN_W-1:0] w, input bit last, input logic [AW-1:0] base);
    bit wr, done, sup;
    int bank, a_int;
    logic [IN_W*PACK-1:0] data;
    logic [NB-1:0] exp_we;
    logic [NB*AW-1:0] exp_vec;
    wr = 0; done = 0; sup = 0; bank = 0; a_int = 0; data = '0;
    @(negedge clk);
    i_vld = vld; i_ofm = w; i_last = last; i_base = base;
    if (vld) begin
      if (!m_active) begin
        m_active = 1; m_base = int'(base); m_lines = 0; m_nw = 0; m_ovf = 0;
      end
      m_buf[m_nw] = w;
      m_nw++;
      if (m_nw == PACK || last) begin
        wr = 1;
        for (int k = 0; k < PACK; k++)
          data[k*IN_W +: IN_W] = (k < m_nw) ? m_buf[k] : '0;
        bank  = m_lines % NB;
        a_int = m_base + m_lines / NB;
`ifdef LAYER_SAVE_OVF_EN
        sup = (a_int > MAXA);
        if (a_int == MAXA) m_ovf = 1;
`endif
        m_lines++;
        m_nw = 0;
        if (last) begin done = 1; m_active = 0; end
      end
    end
    @(posedge clk);
    #1;
    exp_we = '0;
    if (wr && !sup) begin
      exp_we[bank]   = 1'b1;
      exp_addr[bank] = AW'(a_int % (MAXA + 1));
    end
    for (int b = 0; b < NB; b++) exp_vec[b*AW +: AW] = exp_addr[b];
    n_cmp++;
    if (o_we !== exp_we) begin
      n_err++; $display("FAIL we: got %h want %h at %0t", o_we, exp_we, $time);
    end
    n_cmp++;
    if (o_done !== done) begin
      n_err++; $display("FAIL done: got %b want %b at %0t", o_done, done, $time);
    end
    n_cmp++;
    if (o_busy !== m_active) begin
      n_err++; $display("FAIL busy: got %b want %b at %0t", o_busy, m_active, $time);
    end
    n_cmp++;
    if (o_addr !== exp_vec) begin
      n_err++; $display("FAIL addr: got %h want %h at %0t", o_addr, exp_vec, $time);
    end
    if (wr && !sup) begin
      n_cmp++;
      if (o_wdata !== data) begin
        n_err++; $display("FAIL wdata: got %h want %h at %0t", o_wdata, data, $time);
      end
    end
`ifdef LAYER_SAVE_OVF_EN
    n_cmp++;
    if (o_ovf !== m_ovf) begin
      n_err++; $display("FAIL ovf: got %b want %b at %0t", o_ovf, m_ovf, $time);
    end
`endif
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (o_we !== '0 || o_addr !== '0 || o_wdata !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got we=%h addr=%h wdata=%h busy=%b done=%b want all 0",
               tag, o_we, o_addr, o_wdata, o_busy, o_done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; i_vld = 1'b0; i_last = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    check_zero("reset_init");
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 1; k <= 8; k++) step(1, IN_W'(32'h11111111 * k), 0, '0);
    step(0, '0, 0, '0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 68; k++) step(1, $urandom, 0, '0);
    step(0, '0, 0, '0);
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if ((i % 8) < 4) step(1, IN_W'(32'h11111111 * (i / 2 + 1)), 0, '0);
      else             step(0, $urandom, 0, '0);
    end
  endtask

  task automatic test_last();
    do_reset();
    for (int k = 1; k <= 6; k++) step(1, IN_W'(32'h11111111 * k), k == 6, '0);
    for (int k = 1; k <= 5; k++) step(1, $urandom, k == 5, 10'h100);
    step(0, '0, 1, '0);
    step(1, 32'hABCD0001, 1, 10'h055);
    step(1, 32'hABCD0002, 0, 10'h066);
    step(1, 32'hABCD0003, 1, 10'h077);
  endtask

  task automatic test_reset_midline();
    do_reset();
    step(1, 32'hDEAD0001, 0, '0);
    step(1, 32'hDEAD0002, 0, '0);
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, IN_W'(32'h0B0B0000 + k), 0, '0);
    step(0, '0, 0, '0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 17 * PACK; k++) step(1, $urandom, 0, 10'h3FF);
    step(0, '0, 0, '0);
    for (int k = 0; k < 5; k++) step(1, $urandom, k == 4, 10'h3FF);
    step(1, $urandom, 1, 10'h010);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 11) == 0, AW'($urandom));
    step(0, '0, 0, '0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_last();
    test_reset_midline();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
